// File: rtl/l2c_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : l2c_cmd_queue
// Purpose  : Command input queue in front of the L2 cache controller core.
//            Buffers trace commands in a small FIFO and presents the head
//            entry first-word-fall-through, split into tag/index/offset and
//            classified as snoop or maintenance. Illegal command codes are
//            accepted, dropped and counted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   upstream command valid
//   in_ready     out  queue can accept a command (occupancy < DEPTH)
//   in_cmd       in   command code (0-6, 8, 9 legal)
//   in_addr      in   physical address
//   out_valid    out  head entry valid
//   out_ready    in   controller consumes head entry
//   out_cmd      out  head command code
//   out_tag      out  head address tag
//   out_index    out  head address set index
//   out_offset   out  head address line offset
//   out_is_snoop out  head command is 3..6
//   out_is_maint out  head command is 8 or 9
//   err_illegal  out  one-cycle pulse after an illegal command is dropped
//   drop_cnt     out  saturating count of dropped commands
//   occupancy    out  number of valid entries
// ============================================================================
module l2c_cmd_queue #(
  parameter int DEPTH     = 4,
  parameter int PA_BITS   = 32,
  parameter int LINE_ADDR = 6,
  parameter int INDEX_LEN = 14,
  parameter int TAG_LEN   = PA_BITS - INDEX_LEN - LINE_ADDR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_cmd,
  input  logic [PA_BITS-1:0]         in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_cmd,
  output logic [TAG_LEN-1:0]         out_tag,
  output logic [INDEX_LEN-1:0]       out_index,
  output logic [LINE_ADDR-1:0]       out_offset,
  output logic                       out_is_snoop,
  output logic                       out_is_maint,
  output logic                       err_illegal,
  output logic [15:0]                drop_cnt,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W-1:0] C_DEPTH   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] C_OCC_ONE = OCC_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [15:0]      C_CNT_MAX = 16'hFFFF;

  logic [3:0]         r_mem_cmd  [DEPTH];
  logic [PA_BITS-1:0] r_mem_addr [DEPTH];

  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic               r_err;
  logic [15:0]        r_drop_cnt;

  logic               w_legal;
  logic               w_push;
  logic               w_push_legal;
  logic               w_push_illegal;
  logic               w_pop;
  logic [3:0]         w_head_cmd;
  logic [PA_BITS-1:0] w_head_addr;

  // Ready depends only on registered occupancy, so a full queue stays
  // not-ready during the cycle it is popped.
  assign in_ready  = (r_occ < C_DEPTH);
  assign out_valid = (r_occ != '0);

  assign w_legal        = (in_cmd <= 4'd6) || (in_cmd == 4'd8) || (in_cmd == 4'd9);
  assign w_push         = in_valid & in_ready;
  assign w_push_legal   = w_push & w_legal;
  assign w_push_illegal = w_push & ~w_legal;
  assign w_pop          = out_valid & out_ready;

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_push_legal) begin
      r_mem_cmd[r_wr_ptr]  <= in_cmd;
      r_mem_addr[r_wr_ptr] <= in_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push_legal) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push_legal, w_pop})
        2'b10:   r_occ <= r_occ + C_OCC_ONE;
        2'b01:   r_occ <= r_occ - C_OCC_ONE;
        default: r_occ <= r_occ;
      endcase
      r_err <= w_push_illegal;
      if (w_push_illegal && (r_drop_cnt != C_CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign w_head_cmd  = r_mem_cmd[r_rd_ptr];
  assign w_head_addr = r_mem_addr[r_rd_ptr];

  // Head fields are forced to zero when nothing is queued so stale storage
  // never leaks onto the controller interface.
  always_comb begin
    out_cmd      = '0;
    out_tag      = '0;
    out_index    = '0;
    out_offset   = '0;
    out_is_snoop = 1'b0;
    out_is_maint = 1'b0;
    if (out_valid) begin
      out_cmd      = w_head_cmd;
      out_tag      = w_head_addr[PA_BITS-1 -: TAG_LEN];
      out_index    = w_head_addr[LINE_ADDR +: INDEX_LEN];
      out_offset   = w_head_addr[LINE_ADDR-1:0];
      out_is_snoop = (w_head_cmd >= 4'd3) && (w_head_cmd <= 4'd6);
      out_is_maint = (w_head_cmd == 4'd8) || (w_head_cmd == 4'd9);
    end
  end

  assign err_illegal = r_err;
  assign drop_cnt    = r_drop_cnt;
  assign occupancy   = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_l2c_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2c_cmd_queue
// Purpose  : Self-checking bench for l2c_cmd_queue. A queue-based reference
//            model tracks what the controller must see; a negedge process
//            compares every output against it, and directed steps carry
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2c_cmd_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_cmd;
  logic [11:0] out_tag;
  logic [13:0] out_index;
  logic [5:0]  out_offset;
  logic        out_is_snoop;
  logic        out_is_maint;
  logic        err_illegal;
  logic [15:0] drop_cnt;
  logic [2:0]  occupancy;

  l2c_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .out_is_snoop(out_is_snoop), .out_is_maint(out_is_maint),
    .err_illegal(err_illegal), .drop_cnt(drop_cnt), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [3:0]  m_cmd_q[$];
  logic [31:0] m_addr_q[$];
  int          m_drop;
  bit          m_err;

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cmd_q.delete();
    m_addr_q.delete();
    m_drop = 0;
    m_err  = 1'b0;
  endtask

  // One clock of stimulus; returns #1 after the rising edge.
  task automatic step(input bit v, input logic [3:0] c, input logic [31:0] a, input bit r);
    bit push, pop, legal;
    in_valid  = v;
    in_cmd    = c;
    in_addr   = a;
    out_ready = r;
    @(posedge clk);
    push  = v && (m_cmd_q.size() < DEPTH);
    pop   = r && (m_cmd_q.size() != 0);
    legal = !((c == 4'd7) || (c >= 4'd10));
    if (pop) begin
      void'(m_cmd_q.pop_front());
      void'(m_addr_q.pop_front());
    end
    if (push && legal) begin
      m_cmd_q.push_back(c);
      m_addr_q.push_back(a);
    end
    m_err = push && !legal;
    if (m_err && m_drop < 65535) m_drop++;
    #1;
  endtask

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready",    32'(in_ready),    32'(m_cmd_q.size() < DEPTH));
      check("out_valid",   32'(out_valid),   32'(m_cmd_q.size() != 0));
      check("occupancy",   32'(occupancy),   32'(m_cmd_q.size()));
      check("err_illegal", 32'(err_illegal), 32'(m_err));
      check("drop_cnt",    32'(drop_cnt),    32'(m_drop));
      if (m_cmd_q.size() != 0) begin
        check("out_cmd",      32'(out_cmd),      32'(m_cmd_q[0]));
        check("out_tag",      32'(out_tag),      m_addr_q[0] >> 20);
        check("out_index",    32'(out_index),    (m_addr_q[0] >> 6) & 32'h3FFF);
        check("out_offset",   32'(out_offset),   m_addr_q[0] & 32'h3F);
        check("out_is_snoop", 32'(out_is_snoop), 32'(m_cmd_q[0] >= 3 && m_cmd_q[0] <= 6));
        check("out_is_maint", 32'(out_is_maint), 32'(m_cmd_q[0] == 8 || m_cmd_q[0] == 9));
      end else begin
        check("idle_fields", {out_tag, out_index, out_offset}, 32'h0);
        check("idle_cmd",    {26'h0, out_cmd, out_is_snoop, out_is_maint}, 32'h0);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cmd    = 4'd0;
    in_addr   = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);

    // Single push into empty queue: visible one edge later, decoded fields.
    step(1'b1, 4'd0, 32'h1234_5678, 1'b0);
    check("t1_out_valid", 32'(out_valid),  32'd1);
    check("t1_tag",       32'(out_tag),    32'h123);
    check("t1_index",     32'(out_index),  32'h1159);
    check("t1_offset",    32'(out_offset), 32'h38);
    check("t1_occupancy", 32'(occupancy),  32'd1);
    step(1'b0, 4'd0, 32'h0, 1'b1);
    check("t1_drained", 32'(out_valid), 32'd0);

    // Fill to full, then a pop and a 5th offer in the same cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 1), 32'h1000_0040 * (i + 1), 1'b0);
    check("full_occupancy", 32'(occupancy), 32'd4);
    check("full_in_ready",  32'(in_ready),  32'd0);
    step(1'b1, 4'd8, 32'hABCD_EF01, 1'b1);
    check("full_pop_occ",   32'(occupancy), 32'd3);
    check("full_pop_ready", 32'(in_ready),  32'd1);
    check("full_pop_head",  32'(out_cmd),   32'd2);
    step(1'b1, 4'd8, 32'hABCD_EF01, 1'b0);
    check("fifth_accepted", 32'(occupancy), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'h0, 1'b1);

    // Offer an illegal code while full without a push: no error pulse.
    for (int i = 0; i < 4; i++) step(1'b1, 4'd1, 32'h0000_0100 + 32'(i), 1'b0);
    step(1'b1, 4'd15, 32'h0, 1'b0);
    check("full_no_err", 32'(err_illegal), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'h0, 1'b1);

    // Illegal codes 7 and 12: dropped and counted.
    step(1'b1, 4'd7, 32'hDEAD_BEEF, 1'b0);
    check("ill7_err",  32'(err_illegal), 32'd1);
    check("ill7_drop", 32'(drop_cnt),    32'd1);
    step(1'b1, 4'd12, 32'hCAFE_0000, 1'b0);
    check("ill12_err",  32'(err_illegal), 32'd1);
    check("ill12_drop", 32'(drop_cnt),    32'd2);
    step(1'b0, 4'd0, 32'h0, 1'b0);
    check("ill_err_clear", 32'(err_illegal), 32'd0);
    check("ill_occ",       32'(occupancy),   32'd0);
    check("ill_out_valid", 32'(out_valid),   32'd0);

    // Steady state at occupancy 2 with push and pop every cycle.
    step(1'b1, 4'd1, 32'h0000_1000, 1'b0);
    step(1'b1, 4'd2, 32'h0000_2000, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i % 7), 32'h0100_0000 + 32'h0004_1041 * i, 1'b1);
    check("steady_occ",  32'(occupancy), 32'd2);
    check("steady_head", 32'(out_cmd),   32'd1);
    // Illegal push together with a pop: occupancy drops by one.
    step(1'b1, 4'd13, 32'h0, 1'b1);
    check("ill_pop_occ", 32'(occupancy),   32'd1);
    check("ill_pop_err", 32'(err_illegal), 32'd1);
    step(1'b0, 4'd0, 32'h0, 1'b1);

    // Classification.
    step(1'b1, 4'd4, 32'h4444_4444, 1'b0);
    step(1'b1, 4'd9, 32'h9999_9999, 1'b0);
    check("cls1_snoop", 32'(out_is_snoop), 32'd1);
    check("cls1_maint", 32'(out_is_maint), 32'd0);
    step(1'b0, 4'd0, 32'h0, 1'b1);
    check("cls2_snoop", 32'(out_is_snoop), 32'd0);
    check("cls2_maint", 32'(out_is_maint), 32'd1);
    step(1'b0, 4'd0, 32'h0, 1'b1);

    // Build 3 entries and drop_cnt = 5, then reset asynchronously.
    step(1'b1, 4'd10, 32'h0, 1'b0);
    step(1'b1, 4'd11, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd5, 32'h0000_0080 * i, 1'b0);
    step(1'b0, 4'd0, 32'h0, 1'b0);
    check("pre_rst_occ",  32'(occupancy), 32'd3);
    check("pre_rst_drop", 32'(drop_cnt),  32'd5);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_occ",       32'(occupancy), 32'd0);
    check("arst_drop",      32'(drop_cnt),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 4'd0, 32'h0, 1'b0);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2c_cmd_queue.md
Name: l2c_cmd_queue

Overview:
- Input stage directly upstream of the L2 cache controller core.
- Accepts trace commands (command code plus physical address) over a valid/ready handshake and buffers them in a small FIFO.
- Splits each address into tag, index and line offset, classifies the command, and presents it to the controller through a first-word-fall-through valid/ready port.
- Drops illegal command codes and counts them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PA_BITS, 32, physical address width; same as the package PA_BITS.
- LINE_ADDR, 6, line offset bits; same as the package L2_LINE_ADDR.
- INDEX_LEN, 14, set index bits; same as the package L2_INDEX_LENGTH.
- TAG_LEN, PA_BITS-INDEX_LEN-LINE_ADDR, tag bits; same as the package L2_TAG_LENGTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  upstream command valid.
- in_ready  out  1  queue can accept a command.
- in_cmd  in  4  command code per TYP_CMD (0-6, 8, 9 legal).
- in_addr  in  PA_BITS  physical address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  controller consumes the head entry.
- out_cmd  out  4  head command code.
- out_tag  out  TAG_LEN  in_addr[PA_BITS-1 -: TAG_LEN].
- out_index  out  INDEX_LEN  in_addr[LINE_ADDR +: INDEX_LEN].
- out_offset  out  LINE_ADDR  in_addr[LINE_ADDR-1:0].
- out_is_snoop  out  1  head command is 3..6 (SNP_INV, SNP_RD, SNP_WR, SNP_RWIM).
- out_is_maint  out  1  head command is 8 or 9 (CLR, DISP).
- err_illegal  out  1  one-cycle pulse: an illegal code was accepted and dropped.
- drop_cnt  out  16  saturating count of dropped illegal commands.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, rst_n=0):
  - read pointer, write pointer, occupancy, drop_cnt = 0.
  - out_valid = 0, err_illegal = 0.
  - in_ready = 1 once rst_n deasserts.
  - Storage contents are don't-care, but the out_* data fields read as 0 while out_valid = 0.
  - Reset asserted mid-operation discards all entries immediately; there is no flush handshake.
- Handshake:
  - Push happens when in_valid & in_ready.
  - Pop happens when out_valid & out_ready.
  - Upstream may change in_* only after a push.
  - in_ready = (occupancy < DEPTH). It is registered-state driven with no combinational path from out_ready: a full queue stays not-ready in the same cycle as a pop.
- Legality check: codes 7 and 10-15 are illegal.
  - An illegal push is accepted (consumes the handshake) but not stored.
  - The next cycle: err_illegal = 1 and drop_cnt increments; drop_cnt saturates at 0xFFFF.
  - occupancy is unchanged by an illegal push.
- Storage: each legal push writes {cmd, addr} at the write pointer, and the write pointer increments. Pointers wrap modulo DEPTH.
- Output (first-word fall-through):
  - out_valid = (occupancy != 0).
  - out_* are decoded combinationally from the head entry.
  - Latency: a push into an empty queue is visible at the output on the next edge (1 cycle). There is no same-cycle bypass.
  - Head fields hold stable while out_valid & !out_ready.
- Occupancy:
  - Legal push and no pop: +1.
  - Pop and no legal push: -1.
  - Both in the same cycle: unchanged, with both pointers advancing.
  - Illegal push plus pop: -1.
- Boundaries:
  - Pop with out_valid = 0 is ignored.
  - Push with in_ready = 0 is ignored and does not affect err_illegal.
  - At full, a simultaneous pop and in_valid accepts nothing that cycle; the push succeeds on the next cycle.
- Classification: a command is flagged in exactly one class or none. Codes 0-2 set neither flag.

Test Plan:
- Reset, then push {cmd=0, addr=0x1234_5678} into the empty queue -> next cycle out_valid=1, out_cmd=0, out_tag=0x123, out_index=0x1159, out_offset=0x38, occupancy=1.
- Push 4 legal commands with out_ready=0 -> occupancy=4, in_ready=0. A 5th in_valid is not accepted. Pop one -> in_ready=1 the next cycle and the 5th push succeeds; FIFO order is preserved.
- Push cmd=7, then cmd=12 -> err_illegal pulses twice, drop_cnt=2, occupancy=0, out_valid remains 0.
- Hold occupancy=2 with simultaneous legal push and pop for 10 cycles -> occupancy stays 2, output order matches input order, and the pointers wrap correctly.
- Push cmd=4 and cmd=9 -> the first head has out_is_snoop=1, out_is_maint=0; the second has out_is_snoop=0, out_is_maint=1.
- Assert rst_n=0 asynchronously with 3 entries queued and drop_cnt=5 -> out_valid=0, occupancy=0, drop_cnt=0 immediately, without waiting for a clock edge.
